// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: multiplicand M, accumulator {C,A,Q}, and a captured product register.
// Optional consumer handshake on the product register is enabled by defining PRODUCT_HANDSHAKE_EN.
module mult_datapath #(
    parameter int n = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           add,
    input  logic           shift,
    input  logic           ready,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    input  logic           product_ack,
    output logic           Q0,
    output logic [2*n-1:0] product,
    output logic           product_valid,
    output logic           overrun,
    output logic           protocol_err
);

    logic [n-1:0]   m_q, m_d;
    logic [n-1:0]   a_q, a_d;
    logic [n-1:0]   q_q, q_d;
    logic           c_q, c_d;
    logic           ready_q;
    logic [2*n-1:0] prod_q, prod_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic           perr_q, perr_d;
    logic           capture_s;

    assign capture_s = ready & ~ready_q;

    // Accumulator/multiplier next state: load > illegal add+shift > add > shift > hold
    always_comb begin
        m_d    = m_q;
        a_d    = a_q;
        q_d    = q_q;
        c_d    = c_q;
        perr_d = perr_q;
        if (load) begin
            m_d = multiplicand;
            q_d = multiplier;
            a_d = '0;
            c_d = 1'b0;
        end else if (add && shift) begin
            perr_d = 1'b1;
        end else if (add) begin
            {c_d, a_d} = {1'b0, a_q} + {1'b0, m_q};
        end else if (shift) begin
            a_d = {c_q, a_q[n-1:1]};
            q_d = {a_q[0], q_q[n-1:1]};
            c_d = 1'b0;
        end else begin
            perr_d = perr_q;
        end
    end

    // Product register and its valid/overrun flags, captured on the ready rising edge
    always_comb begin
        prod_d    = prod_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (capture_s) begin
            prod_d = {a_q, q_q};
        end else begin
            prod_d = prod_q;
        end
`ifdef PRODUCT_HANDSHAKE_EN
        // A capture beats a same-cycle ack; an unacknowledged result being replaced is an overrun
        if (capture_s) begin
            valid_d = 1'b1;
            if (valid_q && !product_ack) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (product_ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
`else
        valid_d   = capture_s;
        overrun_d = 1'b0;
`endif
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            ready_q   <= 1'b0;
            prod_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            c_q       <= c_d;
            ready_q   <= ready;
            prod_q    <= prod_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign Q0            = q_q[0];
    assign product       = prod_q;
    assign product_valid = valid_q;
    assign overrun       = overrun_q;
    assign protocol_err  = perr_q;

`ifndef PRODUCT_HANDSHAKE_EN
    logic unused_s;
    assign unused_s = product_ack;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed-vector bench for mult_datapath (n=4); handshake scenarios run only with PRODUCT_HANDSHAKE_EN.
module tb_mult_datapath;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       add = 1'b0;
    logic       shift = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] multiplicand = 4'd0;
    logic [3:0] multiplier = 4'd0;
    logic       product_ack = 1'b0;
    logic       Q0;
    logic [7:0] product;
    logic       product_valid;
    logic       overrun;
    logic       protocol_err;

    int vectors = 0;
    int miscompares = 0;

    mult_datapath #(.n(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .add          (add),
        .shift        (shift),
        .ready        (ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product_ack  (product_ack),
        .Q0           (Q0),
        .product      (product),
        .product_valid(product_valid),
        .overrun      (overrun),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Load operands then run add/shift pairs; expected Q0 before each add is the matching multiplier bit
    task automatic run_pairs(input logic [3:0] mp, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            vectors++;
            if (Q0 !== mp[i]) begin
                miscompares++;
                $display("FAIL q0_bit%0d: got %b want %b", i, Q0, mp[i]);
            end
            if (mp[i]) begin
                add = 1'b1;
                step();
                add = 1'b0;
            end
            shift = 1'b1;
            step();
            shift = 1'b0;
        end
    endtask

    task automatic do_load(input logic [3:0] mc, input logic [3:0] mp);
        multiplicand = mc;
        multiplier   = mp;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic capture_check(input string name, input logic [7:0] exp_p);
        ready = 1'b1;
        step();
        vectors++;
        if (product !== exp_p || product_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got product=%h valid=%b want product=%h valid=1", name, product, product_valid, exp_p);
        end
        ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({Q0, product, product_valid, overrun, protocol_err} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: got q0=%b p=%h v=%b ov=%b pe=%b want all 0",
                     Q0, product, product_valid, overrun, protocol_err);
        end
    endtask

    task automatic test_basic();
        do_load(4'd13, 4'd11);
        run_pairs(4'd11, 0, 3);
        capture_check("basic_13x11", 8'h8F);
    endtask

    task automatic test_max_and_zero();
        do_load(4'd15, 4'd15);
        run_pairs(4'd15, 0, 3);
        capture_check("max_15x15", 8'hE1);
        do_load(4'd15, 4'd0);
        run_pairs(4'd0, 0, 3);
        capture_check("zero_15x0", 8'h00);
        do_load(4'd15, 4'd15);
        run_pairs(4'd15, 0, 3);
        capture_check("max_again", 8'hE1);
    endtask

    task automatic test_reset_mid_run();
        do_load(4'd13, 4'd11);
        run_pairs(4'd11, 0, 1);
        reset = 1'b1;
        step();
        vectors++;
        if ({Q0, product, product_valid, overrun, protocol_err} !== 12'h000) begin
            miscompares++;
            $display("FAIL midrun_reset: got q0=%b p=%h v=%b ov=%b pe=%b want all 0",
                     Q0, product, product_valid, overrun, protocol_err);
        end
        ready = 1'b1;
        step();
        reset = 1'b0;
        ready = 1'b0;
        step();
        vectors++;
        if (product !== 8'h00 || product_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_no_capture: got product=%h valid=%b want 00/0", product, product_valid);
        end
    endtask

    task automatic test_illegal_strobes();
        do_load(4'd13, 4'd11);
        run_pairs(4'd11, 0, 0);
        add = 1'b1;
        shift = 1'b1;
        step();
        add = 1'b0;
        shift = 1'b0;
        vectors++;
        if (protocol_err !== 1'b1) begin
            miscompares++;
            $display("FAIL perr_set: got %b want 1", protocol_err);
        end
        run_pairs(4'd11, 1, 3);
        capture_check("illegal_hold_product", 8'h8F);
        vectors++;
        if (protocol_err !== 1'b1) begin
            miscompares++;
            $display("FAIL perr_sticky: got %b want 1", protocol_err);
        end
        test_reset();
    endtask

`ifndef PRODUCT_HANDSHAKE_EN
    task automatic test_pulse_mode();
        int highs;
        do_load(4'd3, 4'd5);
        run_pairs(4'd5, 0, 3);
        highs = 0;
        ready = 1'b1;
        product_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (product_valid === 1'b1) highs++;
            vectors++;
            if (product !== 8'h0F || overrun !== 1'b0) begin
                miscompares++;
                $display("FAIL pulse_product_cyc%0d: got product=%h ov=%b want 0f/0", k, product, overrun);
            end
            // Reloading while ready stays high would change {A,Q} if a second capture occurred
            multiplicand = 4'd2;
            multiplier = 4'd3;
            load = 1'b1;
        end
        load = 1'b0;
        ready = 1'b0;
        product_ack = 1'b0;
        step();
        vectors++;
        if (highs !== 1) begin
            miscompares++;
            $display("FAIL pulse_width: got %0d cycles want 1", highs);
        end
    endtask
`else
    task automatic test_handshake();
        do_load(4'd2, 4'd3);
        run_pairs(4'd3, 0, 3);
        capture_check("hs_first", 8'h06);
        do_load(4'd3, 4'd5);
        run_pairs(4'd5, 0, 3);
        capture_check("hs_second", 8'h0F);
        vectors++;
        if (overrun !== 1'b1 || product !== 8'h0F || product_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_overrun: got ov=%b p=%h v=%b want 1/0f/1", overrun, product, product_valid);
        end
        do_load(4'd1, 4'd1);
        run_pairs(4'd1, 0, 3);
        product_ack = 1'b1;
        ready = 1'b1;
        step();
        product_ack = 1'b0;
        ready = 1'b0;
        vectors++;
        if (product_valid !== 1'b1 || product !== 8'h01) begin
            miscompares++;
            $display("FAIL hs_capture_beats_ack: got v=%b p=%h want 1/01", product_valid, product);
        end
        product_ack = 1'b1;
        step();
        product_ack = 1'b0;
        vectors++;
        if (product_valid !== 1'b0 || overrun !== 1'b1 || product !== 8'h01) begin
            miscompares++;
            $display("FAIL hs_ack_clears: got v=%b ov=%b p=%h want 0/1/01", product_valid, overrun, product);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max_and_zero();
        test_reset_mid_run();
        test_illegal_strobes();
`ifndef PRODUCT_HANDSHAKE_EN
        test_pulse_mode();
`else
        test_handshake();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
